// File: rtl/basic_mux_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : basic_mux_sel_ctrl_if
// Brief   : Select-control bundle between the external select inputs and the
//           mux address/enable outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface basic_mux_sel_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              ctrl_ena;
    logic              sel_rst;
    logic              sel_inc;
    logic [ADDR_W-1:0] addr;
    logic              ena;
    logic              settling;

    modport master (
        output ctrl_ena, sel_rst, sel_inc,
        input  addr, ena, settling
    );

    modport slave (
        input  ctrl_ena, sel_rst, sel_inc,
        output addr, ena, settling
    );
endinterface
`default_nettype wire

// File: rtl/basic_mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : basic_mux_sel_ctrl
// Brief   : Turns slow select controls into a registered addr/ena pair with a
//           guard window after every change. Option macro: SEL_SYNC_EN.
// Revision: 1.0 - initial release
// ============================================================================
module basic_mux_sel_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int NUM_PROJECTS = 8,
    parameter int GUARD_CYCLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    basic_mux_sel_ctrl_if.slave     bus
);

    localparam logic [1:0]      S_IDLE         = 2'd0;
    localparam logic [1:0]      S_SETTLE       = 2'd1;
    localparam logic [1:0]      S_ACTIVE       = 2'd2;
    localparam logic [7:0]      c_guard_reload = 8'(GUARD_CYCLES - 1);
    localparam logic [ADDR_W:0] c_num_projects = (ADDR_W+1)'(NUM_PROJECTS);
    localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);

    logic w_ctrl_ena;
    logic w_sel_rst;
    logic w_sel_inc;

`ifdef SEL_SYNC_EN
    // Order {ctrl_ena, sel_rst, sel_inc}; sel_inc idles high so release is not an edge
    logic [2:0] r_sync_1;
    logic [2:0] r_sync_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_1 <= 3'b001;
            r_sync_2 <= 3'b001;
        end else begin
            r_sync_1 <= {bus.ctrl_ena, bus.sel_rst, bus.sel_inc};
            r_sync_2 <= r_sync_1;
        end
    end

    assign {w_ctrl_ena, w_sel_rst, w_sel_inc} = r_sync_2;
`else
    assign w_ctrl_ena = bus.ctrl_ena;
    assign w_sel_rst  = bus.sel_rst;
    assign w_sel_inc  = bus.sel_inc;
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_ena;
    logic              w_ena_nxt;
    logic              r_settling;
    logic              w_settling_nxt;
    logic              r_sel_inc_q;
    logic              w_inc_edge;
    logic              w_change;

    assign w_inc_edge = w_sel_inc & ~r_sel_inc_q;
    assign w_change   = w_ctrl_ena & (w_sel_rst | w_inc_edge);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_addr      <= '0;
            r_ena       <= 1'b0;
            r_settling  <= 1'b0;
            r_sel_inc_q <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_ena       <= w_ena_nxt;
            r_settling  <= w_settling_nxt;
            r_sel_inc_q <= w_sel_inc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;

        if (w_ctrl_ena) begin
            if (w_sel_rst) begin
                w_addr_nxt = '0;
            end else if (w_inc_edge) begin
                w_addr_nxt = r_addr + c_addr_one;
            end
        end

        if (!w_ctrl_ena) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = c_guard_reload;
                end
                S_SETTLE: begin
                    if (w_change) begin
                        w_cnt_nxt = c_guard_reload;
                    end else if (r_cnt == 8'd0) begin
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (w_change) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = c_guard_reload;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Outputs follow the next state so ena drops on the same edge addr moves
    always_comb begin
        w_ena_nxt      = (w_state_nxt == S_ACTIVE) && ({1'b0, w_addr_nxt} < c_num_projects);
        w_settling_nxt = (w_state_nxt == S_SETTLE);
    end

    assign bus.addr     = r_addr;
    assign bus.ena      = r_ena;
    assign bus.settling = r_settling;

endmodule
`default_nettype wire

// File: tb/tb_basic_mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_basic_mux_sel_ctrl
// Brief   : Directed scoreboard bench for basic_mux_sel_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_basic_mux_sel_ctrl;

    localparam int ADDR_W       = 5;
    localparam int NUM_PROJECTS = 8;
    localparam int GUARD_CYCLES = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              ena;
        logic              settling;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [ADDR_W-1:0] m_addr;
    logic              m_prev;
    int                m_mode;   // 0 idle, 1 settle, 2 active
    int                m_wait;
    logic [2:0]        m_pipe1;
    logic [2:0]        m_pipe2;

    basic_mux_sel_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    basic_mux_sel_ctrl #(
        .ADDR_W       (ADDR_W),
        .NUM_PROJECTS (NUM_PROJECTS),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, predict, push, then pop and compare after the edge
    task automatic cyc(input logic r, input logic c, input logic s, input logic i);
        exp_t e;
        exp_t got;
        logic ce, se, ie, rise;
        rst          = r;
        bus.ctrl_ena = c;
        bus.sel_rst  = s;
        bus.sel_inc  = i;
        if (r) begin
            m_addr  = '0;
            m_prev  = 1'b1;
            m_mode  = 0;
            m_wait  = 0;
            m_pipe1 = 3'b001;
            m_pipe2 = 3'b001;
        end else begin
`ifdef SEL_SYNC_EN
            {ce, se, ie} = m_pipe2;
            m_pipe2      = m_pipe1;
            m_pipe1      = {c, s, i};
`else
            ce = c;
            se = s;
            ie = i;
`endif
            rise   = ie & ~m_prev;
            m_prev = ie;
            if (!ce) begin
                m_mode = 0;
            end else begin
                if (se)        m_addr = '0;
                else if (rise) m_addr = m_addr + 1'b1;
                if (m_mode == 0 || se || rise) begin
                    m_mode = 1;
                    m_wait = GUARD_CYCLES - 1;
                end else if (m_mode == 1) begin
                    if (m_wait == 0) m_mode = 2;
                    else             m_wait = m_wait - 1;
                end
            end
        end
        e.addr     = m_addr;
        e.ena      = (m_mode == 2) && (int'(m_addr) < NUM_PROJECTS);
        e.settling = (m_mode == 1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("sb_addr",     32'(bus.addr),     32'(got.addr));
        chk("sb_ena",      32'(bus.ena),      32'(got.ena));
        chk("sb_settling", 32'(bus.settling), 32'(got.settling));
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulse(input int gap);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        idle(gap);
    endtask

    initial begin
        rst          = 1'b1;
        bus.ctrl_ena = 1'b0;
        bus.sel_rst  = 1'b0;
        bus.sel_inc  = 1'b0;

        // 1: reset then enable
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_addr",     32'(bus.addr),     32'd0);
        chk("rst_ena",      32'(bus.ena),      32'd0);
        chk("rst_settling", 32'(bus.settling), 32'd0);
        idle(6);
        idle(4);
        chk("t1_ena", 32'(bus.ena), 32'd1);

        // 2: three spaced increments
        repeat (3) pulse(9);
        idle(4);
        chk("t2_addr", 32'(bus.addr), 32'd3);
        chk("t2_ena",  32'(bus.ena),  32'd1);

        // 3: beyond populated slots, then wrap
        repeat (5) pulse(1);
        idle(10);
        chk("t3_addr8", 32'(bus.addr),     32'd8);
        chk("t3_ena8",  32'(bus.ena),      32'd0);
        chk("t3_set8",  32'(bus.settling), 32'd0);
        repeat (23) pulse(1);
        idle(6);
        chk("t3_addr31", 32'(bus.addr), 32'd31);
        chk("t3_ena31",  32'(bus.ena),  32'd0);
        pulse(9);
        idle(2);
        chk("t3_wrap_addr", 32'(bus.addr), 32'd0);
        chk("t3_wrap_ena",  32'(bus.ena),  32'd1);

        // 4: sel_rst beats a simultaneous edge
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (5) pulse(1);
        idle(8);
        chk("t4_addr5", 32'(bus.addr), 32'd5);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_held_addr", 32'(bus.addr), 32'd0);
        idle(6);
        chk("t4_addr0", 32'(bus.addr), 32'd0);
        chk("t4_ena",   32'(bus.ena),  32'd1);

        // 5: dense pulses keep retriggering; start at 24 so the result wraps into range
        repeat (24) pulse(1);
        repeat (10) pulse(1);
        idle(6);
        chk("t5_addr", 32'(bus.addr), 32'd2);
        chk("t5_ena",  32'(bus.ena),  32'd1);
        repeat (10) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t5_off_addr", 32'(bus.addr),     32'd2);
        chk("t5_off_ena",  32'(bus.ena),      32'd0);
        chk("t5_off_set",  32'(bus.settling), 32'd0);

        // 6: reset during SETTLE
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (6) pulse(1);
        idle(8);
        chk("t6_addr6", 32'(bus.addr), 32'd6);
        chk("t6_ena6",  32'(bus.ena),  32'd1);
        pulse(1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_rst_addr", 32'(bus.addr),     32'd0);
        chk("t6_rst_ena",  32'(bus.ena),      32'd0);
        chk("t6_rst_set",  32'(bus.settling), 32'd0);
        idle(10);
        chk("t6_end_ena", 32'(bus.ena), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
